// File: rtl/bgr_pixel_unpacker_if.sv
// rtl/bgr_pixel_unpacker_if.sv - byte stream in / RGB pixel out bundle for bgr_pixel_unpacker
interface bgr_pixel_unpacker_if #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
);
    localparam int CW = $clog2(IMG_WIDTH) + 1;
    localparam int RW = $clog2(IMG_HEIGHT) + 1;

    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic [7:0]    red_o;
    logic [7:0]    green_o;
    logic [7:0]    blue_o;
    logic          done_o;
    logic          pixel_ready_i;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;

    modport slave (
        input  byte_i, byte_valid_i, pixel_ready_i,
        output byte_ready_o, red_o, green_o, blue_o, done_o, col_o, row_o
    );

    modport master (
        output byte_i, byte_valid_i, pixel_ready_i,
        input  byte_ready_o, red_o, green_o, blue_o, done_o, col_o, row_o
    );
endinterface

// File: rtl/bgr_pixel_unpacker.sv
// rtl/bgr_pixel_unpacker.sv - BMP B,G,R byte stream to RGB pixels with row pad removal
// Optional macro BGR_PIXEL_CNT_EN adds pixel_count_o.
module bgr_pixel_unpacker #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        frame_done_o,
`ifdef BGR_PIXEL_CNT_EN
    output logic [31:0] pixel_count_o,
`endif
    bgr_pixel_unpacker_if.slave bus
);
    localparam int CW        = $clog2(IMG_WIDTH) + 1;
    localparam int RW        = $clog2(IMG_HEIGHT) + 1;
    localparam int PAD_BYTES = (4 - (3 * IMG_WIDTH) % 4) % 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    PAD_LAST = 2'((PAD_BYTES == 0) ? 0 : PAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

    state_t        state;
    logic [1:0]    phase;
    logic [1:0]    pad_cnt;
    logic [7:0]    b_hold;
    logic [7:0]    g_hold;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          accept;
    logic          consume;

    // Only the R byte needs the output register free, so B and G keep flowing under stall.
    always_comb begin
        bus.byte_ready_o = 1'b0;
        case (state)
            RUN:     bus.byte_ready_o = !(phase == 2'd2 && bus.done_o && !bus.pixel_ready_i);
            PAD:     bus.byte_ready_o = 1'b1;
            default: bus.byte_ready_o = 1'b0;
        endcase
    end

    assign accept  = bus.byte_valid_i && bus.byte_ready_o;
    assign consume = bus.done_o && bus.pixel_ready_i;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= 2'd0;
            pad_cnt       <= 2'd0;
            b_hold        <= 8'd0;
            g_hold        <= 8'd0;
            col_cnt       <= '0;
            row_cnt       <= '0;
            bus.red_o     <= 8'd0;
            bus.green_o   <= 8'd0;
            bus.blue_o    <= 8'd0;
            bus.done_o    <= 1'b0;
            bus.col_o     <= '0;
            bus.row_o     <= '0;
            frame_done_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (consume)
                bus.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        phase   <= 2'd0;
                        pad_cnt <= 2'd0;
                        col_cnt <= '0;
                        row_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        case (phase)
                            2'd0: begin
                                b_hold <= bus.byte_i;
                                phase  <= 2'd1;
                            end
                            2'd1: begin
                                g_hold <= bus.byte_i;
                                phase  <= 2'd2;
                            end
                            default: begin
                                bus.red_o   <= bus.byte_i;
                                bus.green_o <= g_hold;
                                bus.blue_o  <= b_hold;
                                bus.col_o   <= col_cnt;
                                bus.row_o   <= row_cnt;
                                bus.done_o  <= 1'b1;
                                phase       <= 2'd0;
                                if (col_cnt == COL_LAST) begin
                                    if (PAD_BYTES != 0) begin
                                        state   <= PAD;
                                        pad_cnt <= 2'd0;
                                    end else if (row_cnt == ROW_LAST) begin
                                        state <= DRAIN;
                                    end else begin
                                        col_cnt <= '0;
                                        row_cnt <= row_cnt + 1'b1;
                                    end
                                end else begin
                                    col_cnt <= col_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                PAD: begin
                    if (accept) begin
                        if (pad_cnt == PAD_LAST) begin
                            col_cnt <= '0;
                            if (row_cnt == ROW_LAST) begin
                                state <= DRAIN;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                                state   <= RUN;
                            end
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (!bus.done_o || consume) begin
                        frame_done_o <= 1'b1;
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BGR_PIXEL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pixel_count_o <= 32'd0;
        else if (state == IDLE && start_i)
            pixel_count_o <= 32'd0;
        else if (consume)
            pixel_count_o <= pixel_count_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_bgr_pixel_unpacker.sv
// tb/tb_bgr_pixel_unpacker.sv - scoreboard bench for bgr_pixel_unpacker (3x4 frame, 3 pad bytes per row)
module tb_bgr_pixel_unpacker;
    localparam int W    = 3;
    localparam int H    = 4;
    localparam int CW   = $clog2(W) + 1;
    localparam int RW   = $clog2(H) + 1;
    localparam int PAD  = 3;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } pix_t;

    logic clk;
    logic rst;
    logic start_i;
    logic busy_o;
    logic frame_done_o;
`ifdef BGR_PIXEL_CNT_EN
    logic [31:0] pixel_count_o;
`endif

    bgr_pixel_unpacker_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    bgr_pixel_unpacker #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
`ifdef BGR_PIXEL_CNT_EN
        .pixel_count_o(pixel_count_o),
`endif
        .bus          (bus.slave)
    );

    pix_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   fd_count = 0;
    int   consumed = 0;
    int   pushed = 0;
    int   stall_left = 0;
    bit   rand_ready = 0;
    bit   mon_en = 1;
    bit   abort = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        return (v == 8'hEE) ? 8'h5A : v;
    endfunction

    // Downstream ready: forced stalls take priority over random or always-ready mode.
    initial begin
        bus.pixel_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.pixel_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.pixel_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every consumed pixel and checks stall stability.
    initial begin
        bit          prev_stall;
        logic [29:0] prev_val;
        logic [29:0] cur;
        pix_t        e;
        prev_stall = 0;
        prev_val   = '0;
        forever begin
            @(negedge clk);
            if (frame_done_o) fd_count++;
            cur = {bus.red_o, bus.green_o, bus.blue_o, bus.col_o, bus.row_o};
            if (mon_en) begin
                if (prev_stall) begin
                    check("hold_done", 32'(bus.done_o), 32'd1);
                    check("hold_data", 32'(cur), 32'(prev_val));
                end
                prev_stall = bus.done_o && !bus.pixel_ready_i;
                prev_val   = cur;
                if (bus.done_o && bus.pixel_ready_i) begin
                    consumed++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'({e.r, e.g, e.b}));
                        check("pix_pos", 32'({bus.col_o, bus.row_o}), 32'({e.col, e.row}));
                    end
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input bit fixed_first);
        logic [7:0] bytes[$];
        bit         is_pad[$];
        pix_t       pl[$];
        pix_t       p;
        int         nonpad;
        int         pix;
        int         waited;
        bit         exp_rdy;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p.b = rnd_byte();
                p.g = rnd_byte();
                p.r = rnd_byte();
                if (fixed_first && r == 0 && c == 0) begin
                    p.b = 8'd10;
                    p.g = 8'd20;
                    p.r = 8'd30;
                end
                p.col = CW'(c);
                p.row = RW'(r);
                pl.push_back(p);
                bytes.push_back(p.b); is_pad.push_back(0);
                bytes.push_back(p.g); is_pad.push_back(0);
                bytes.push_back(p.r); is_pad.push_back(0);
            end
            for (int k = 0; k < PAD; k++) begin
                bytes.push_back(8'hEE);
                is_pad.push_back(1);
            end
        end
        nonpad = 0;
        pix    = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus.byte_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.byte_i       = bytes[i];
            bus.byte_valid_i = 1'b1;
            waited = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    bus.byte_valid_i = 1'b0;
                    return;
                end
                exp_rdy = is_pad[i] ? 1'b1 :
                          ((nonpad % 3 == 2) ? !(bus.done_o && !bus.pixel_ready_i) : 1'b1);
                check("byte_ready", 32'(bus.byte_ready_o), 32'(exp_rdy));
                if (bus.byte_ready_o) break;
                waited++;
                if (waited > 200) begin
                    check("byte_timeout", 32'd0, 32'd1);
                    bus.byte_valid_i = 1'b0;
                    return;
                end
            end
            if (!is_pad[i] && nonpad % 3 == 2) begin
                exp_q.push_back(pl[pix]);
                pushed++;
            end
            @(posedge clk);
            #1;
            if (!is_pad[i]) begin
                if (nonpad % 3 == 2) begin
                    check("latency_done", 32'(bus.done_o), 32'd1);
                    check("latency_red", 32'(bus.red_o), 32'(pl[pix].r));
                    pix++;
                end
                nonpad++;
            end
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic finish_frame(input int fd0, input int cons0);
        int k;
        for (k = 0; k < 1000 && busy_o; k++) @(negedge clk);
        if (k == 1000) check("frame_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("frame_done_once", 32'(fd_count - fd0), 32'd1);
        check("pixels_consumed", 32'(consumed - cons0), 32'(NPIX));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_byte_ready", 32'(bus.byte_ready_o), 32'd0);
        check("idle_done", 32'(bus.done_o), 32'd0);
`ifdef BGR_PIXEL_CNT_EN
        check("pixel_count", pixel_count_o, 32'(NPIX));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        int cons0;
        int base;
        rst              = 1'b1;
        start_i          = 1'b0;
        bus.byte_i       = 8'd0;
        bus.byte_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({bus.done_o, bus.red_o, bus.green_o, bus.blue_o}), 32'd0);
        check("rst_status", 32'({busy_o, frame_done_o, bus.byte_ready_o, bus.col_o, bus.row_o}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1: always ready, continuous bytes, first pixel 10/20/30
        fd0 = fd_count; cons0 = consumed;
        start_frame();
        send_frame(0, 1'b1);
        finish_frame(fd0, cons0);

        // Frame 2: random backpressure and byte gaps plus a forced 5-cycle stall
        rand_ready = 1;
        fd0 = fd_count; cons0 = consumed; base = pushed;
        start_frame();
        fork
            send_frame(30, 1'b0);
            begin
                for (int k = 0; k < 2000 && pushed < base + 2; k++) @(negedge clk);
                stall_left = 5;
            end
        join
        finish_frame(fd0, cons0);

        // Frame 3: start while busy is ignored, then reset aborts mid-frame
        rand_ready = 0;
        base = pushed;
        start_frame();
        fork
            send_frame(0, 1'b0);
            begin
                for (int k = 0; k < 2000 && pushed < base + 5; k++) @(negedge clk);
                @(posedge clk);
                #1 start_i = 1'b1;
                @(posedge clk);
                #1 start_i = 1'b0;
                for (int k = 0; k < 2000 && pushed < base + 7; k++) @(negedge clk);
                @(posedge clk);
                #3;
                fd0    = fd_count;
                rst    = 1'b1;
                mon_en = 0;
                abort  = 1;
                #1;
                check("midrst_outputs", 32'({bus.done_o, bus.red_o, bus.green_o, bus.blue_o}), 32'd0);
                check("midrst_status", 32'({busy_o, frame_done_o, bus.byte_ready_o, bus.col_o, bus.row_o}), 32'd0);
            end
        join
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge clk);
        check("no_frame_done_after_rst", 32'(fd_count - fd0), 32'd0);
        abort  = 0;
        mon_en = 1;

        // Frame 4: clean frame after abort, random ready and gaps
        rand_ready = 1;
        fd0 = fd_count; cons0 = consumed;
        start_frame();
        send_frame(20, 1'b1);
        finish_frame(fd0, cons0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
